// File: rtl/robot_nav_core.sv
// Navigation core of the pipe-cleaner robot: wall map, robot position,
// sensor/decision unit and advance unit, sequenced by a 4-phase step cycle.
module robot_nav_core #(
  parameter logic [63:0] WALLS   = 64'h0,
  parameter logic [2:0]  START_X = 3'd0,
  parameter logic [2:0]  START_Y = 3'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] orientacao,
  input  logic       under,
  input  logic       barreira,
  output logic       head,
  output logic       left,
  output logic       avancar,
  output logic       girar,
  output logic       remover,
  output logic [2:0] acao,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y
);

  typedef enum logic [1:0] {
    PH_MAP    = 2'd0,
    PH_DECIDE = 2'd1,
    PH_ISSUE  = 2'd2,
    PH_UPDATE = 2'd3
  } phase_t;

  phase_t     ph, ph_n;
  logic       head_n, left_n, avancar_n, girar_n, remover_n;
  logic [2:0] acao_n, pos_x_n, pos_y_n;

  // Directions are 0=N 1=E 2=S 3=W; leaving the 8x8 grid counts as a wall.
  function automatic logic blocked(input logic [2:0] x, input logic [2:0] y,
                                   input logic [1:0] dir);
    logic [2:0] nx, ny;
    logic       oob;
    nx  = x;
    ny  = y;
    oob = 1'b0;
    case (dir)
      2'd0: begin oob = (y == 3'd0); ny = y - 3'd1; end
      2'd1: begin oob = (x == 3'd7); nx = x + 3'd1; end
      2'd2: begin oob = (y == 3'd7); ny = y + 3'd1; end
      default: begin oob = (x == 3'd0); nx = x - 3'd1; end
    endcase
    return oob || WALLS[{ny, nx}];
  endfunction

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    ph_n      = phase_t'(ph + 2'd1);
    head_n    = head;
    left_n    = left;
    avancar_n = avancar;
    girar_n   = girar;
    remover_n = remover;
    acao_n    = acao;
    pos_x_n   = pos_x;
    pos_y_n   = pos_y;
    case (ph)
      PH_MAP: begin
        acao_n = 3'd0;
        if (orientacao[2]) begin
          head_n = 1'b1;
          left_n = 1'b1;
        end else begin
          head_n = blocked(pos_x, pos_y, orientacao[1:0]);
          // Counter-clockwise neighbour: N->W, E->N, S->E, W->S.
          left_n = blocked(pos_x, pos_y, orientacao[1:0] - 2'd1);
        end
      end
      PH_DECIDE: begin
        avancar_n = 1'b0;
        girar_n   = 1'b0;
        remover_n = 1'b0;
        if (under)                   remover_n = 1'b1;
        else if (!head && !barreira) avancar_n = 1'b1;
        else if (!head)              remover_n = 1'b1;
        else                         girar_n   = 1'b1;
      end
      PH_ISSUE: begin
        avancar_n = 1'b0;
        girar_n   = 1'b0;
        remover_n = 1'b0;
        acao_n    = (avancar && !orientacao[2]) ? orientacao + 3'd1 : 3'd0;
      end
      default: begin
        // Re-check the target so a move off the grid or into a wall is dropped.
        if (acao >= 3'd1 && acao <= 3'd4) begin
          if (!blocked(pos_x, pos_y, 2'(acao - 3'd1))) begin
            case (2'(acao - 3'd1))
              2'd0:    pos_y_n = pos_y - 3'd1;
              2'd1:    pos_x_n = pos_x + 3'd1;
              2'd2:    pos_y_n = pos_y + 3'd1;
              default: pos_x_n = pos_x - 3'd1;
            endcase
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values of the previous cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ph      <= PH_MAP;
      head    <= 1'b0;
      left    <= 1'b0;
      avancar <= 1'b0;
      girar   <= 1'b0;
      remover <= 1'b0;
      acao    <= 3'd0;
      pos_x   <= START_X;
      pos_y   <= START_Y;
    end else begin
      ph      <= ph_n;
      head    <= head_n;
      left    <= left_n;
      avancar <= avancar_n;
      girar   <= girar_n;
      remover <= remover_n;
      acao    <= acao_n;
      pos_x   <= pos_x_n;
      pos_y   <= pos_y_n;
    end
  end

endmodule

// File: tb/tb_robot_nav_core.sv
// Self-checking bench for robot_nav_core: three instances with different maps
// and start cells share one stimulus stream and are checked against a grid model.
module tb_robot_nav_core;

  localparam int N = 3;
  // Instance 0: empty map at (0,0); 1: wall at (1,0), start (0,0); 2: start (7,3).
  localparam logic [N-1:0][63:0] WALLS_T = {
    64'h1000_0040_0000_2000,
    64'h0081_4200_2418_0002,
    64'h0000_0000_0000_0000
  };
  localparam logic [N-1:0][2:0] SX_T = {3'd7, 3'd0, 3'd0};
  localparam logic [N-1:0][2:0] SY_T = {3'd3, 3'd0, 3'd0};

  logic       clock;
  logic       reset;
  logic [2:0] orientacao;
  logic       under;
  logic       barreira;
  logic       head_o    [N];
  logic       left_o    [N];
  logic       avancar_o [N];
  logic       girar_o   [N];
  logic       remover_o [N];
  logic [2:0] acao_o    [N];
  logic [2:0] pos_x_o   [N];
  logic [2:0] pos_y_o   [N];

  int checks = 0;
  int errors = 0;
  int mx [N];
  int my [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    robot_nav_core #(
      .WALLS  (WALLS_T[g]),
      .START_X(SX_T[g]),
      .START_Y(SY_T[g])
    ) dut (
      .clock     (clock),
      .reset     (reset),
      .orientacao(orientacao),
      .under     (under),
      .barreira  (barreira),
      .head      (head_o[g]),
      .left      (left_o[g]),
      .avancar   (avancar_o[g]),
      .girar     (girar_o[g]),
      .remover   (remover_o[g]),
      .acao      (acao_o[g]),
      .pos_x     (pos_x_o[g]),
      .pos_y     (pos_y_o[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: a cell is blocked when it lies off the grid or is marked as a wall.
  function automatic bit wall_at(input int i, input int x, input int y);
    if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b1;
    return WALLS_T[i][y*8 + x];
  endfunction

  function automatic int step_dx(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int step_dy(input int d);
    return (d == 0) ? -1 : (d == 2) ? 1 : 0;
  endfunction

  function automatic logic [13:0] snap(input int i);
    return {head_o[i], left_o[i], avancar_o[i], girar_o[i], remover_o[i],
            acao_o[i], pos_x_o[i], pos_y_o[i]};
  endfunction

  function automatic logic [13:0] pack_exp(input bit h, input bit l, input bit a,
                                           input bit g, input bit r, input int ac,
                                           input int x, input int y);
    return {h, l, a, g, r, 3'(ac), 3'(x), 3'(y)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = int'(SX_T[i]);
      my[i] = int'(SY_T[i]);
    end
  endtask

  // Drives one full 4-clock navigation step and compares every instance after each edge.
  task automatic run_step(input int o, input bit u, input bit b, input string tag);
    bit          eh [N];
    bit          el [N];
    bit          ea [N];
    bit          eg [N];
    bit          er [N];
    int          ec [N];
    int          nx [N];
    int          ny [N];
    logic [13:0] exp_v;
    orientacao = 3'(o);
    under      = u;
    barreira   = b;
    for (int i = 0; i < N; i++) begin
      if (o > 3) begin
        eh[i] = 1'b1;
        el[i] = 1'b1;
      end else begin
        eh[i] = wall_at(i, mx[i] + step_dx(o), my[i] + step_dy(o));
        el[i] = wall_at(i, mx[i] + step_dx((o + 3) % 4), my[i] + step_dy((o + 3) % 4));
      end
      er[i] = u || (!eh[i] && b);
      ea[i] = !u && !eh[i] && !b;
      eg[i] = !u && eh[i];
      ec[i] = ea[i] ? o + 1 : 0;
      nx[i] = ea[i] ? mx[i] + step_dx(o) : mx[i];
      ny[i] = ea[i] ? my[i] + step_dy(o) : my[i];
    end
    for (int p = 0; p < 4; p++) begin
      @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        case (p)
          0: exp_v = pack_exp(eh[i], el[i], 0, 0, 0, 0, mx[i], my[i]);
          1: exp_v = pack_exp(eh[i], el[i], ea[i], eg[i], er[i], 0, mx[i], my[i]);
          2: exp_v = pack_exp(eh[i], el[i], 0, 0, 0, ec[i], mx[i], my[i]);
          default: exp_v = pack_exp(eh[i], el[i], 0, 0, 0, ec[i], nx[i], ny[i]);
        endcase
        checks++;
        if (snap(i) !== exp_v) begin
          errors++;
          $display("FAIL %s inst%0d phase%0d: got h/l/av/gi/rm/acao/x/y=%b expected %b (o=%0d u=%0d b=%0d)",
                   tag, i, p, snap(i), exp_v, o, u, b);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      mx[i] = nx[i];
      my[i] = ny[i];
    end
  endtask

  task automatic test_reset();
    logic [13:0] exp_v;
    reset      = 1'b0;
    orientacao = 3'd0;
    under      = 1'b0;
    barreira   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    model_reset();
    for (int i = 0; i < N; i++) begin
      exp_v = pack_exp(0, 0, 0, 0, 0, 0, mx[i], my[i]);
      checks++;
      if (snap(i) !== exp_v) begin
        errors++;
        $display("FAIL reset inst%0d: got %b expected %b", i, snap(i), exp_v);
      end
    end
    reset = 1'b1;
  endtask

  // East from reset: inst0 moves to (1,0); inst1 faces a wall; inst2 faces the east edge.
  task automatic test_open_move();
    run_step(1, 0, 0, "open_move");
    checks++;
    if (pos_x_o[0] !== 3'd1) begin
      errors++;
      $display("FAIL open_move_pos_x: got %0d expected 1", pos_x_o[0]);
    end
    checks++;
    if (pos_x_o[1] !== 3'd0) begin
      errors++;
      $display("FAIL wall_ahead_pos_x: got %0d expected 0", pos_x_o[1]);
    end
    checks++;
    if (pos_x_o[2] !== 3'd7) begin
      errors++;
      $display("FAIL edge_pos_x: got %0d expected 7", pos_x_o[2]);
    end
  endtask

  task automatic test_dirt();
    run_step(1, 1, 0, "dirt");
    run_step(2, 1, 1, "dirt_and_barrier");
  endtask

  task automatic test_barrier();
    run_step(2, 0, 1, "barrier_s");
    run_step(0, 0, 1, "barrier_n");
  endtask

  task automatic test_invalid_heading();
    run_step(5, 0, 0, "invalid_heading");
    run_step(7, 1, 0, "invalid_heading_dirt");
  endtask

  task automatic test_random();
    int o;
    for (int n = 0; n < 80; n++) begin
      o = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      run_step(o, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) run_step(2, 0, 0, "b2b_south");
    for (int n = 0; n < 3; n++) run_step(3, 0, 0, "b2b_west");
  endtask

  // Reset asserted during the ISSUE cycle of a move discards the pending action.
  task automatic test_reset_mid_step();
    logic [13:0] exp_v;
    orientacao = 3'd2;
    under      = 1'b0;
    barreira   = 1'b0;
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    model_reset();
    for (int i = 0; i < N; i++) begin
      exp_v = pack_exp(0, 0, 0, 0, 0, 0, mx[i], my[i]);
      checks++;
      if (snap(i) !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_step inst%0d: got %b expected %b", i, snap(i), exp_v);
      end
    end
    reset = 1'b1;
    run_step(1, 0, 0, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_open_move();
    test_dirt();
    test_barrier();
    test_invalid_heading();
    test_back_to_back();
    test_random();
    test_reset_mid_step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
